// File: rtl/vram_rect_fill.sv
`timescale 1ns/1ps
// Rectangle-fill engine: turns one (x, y, w, h, colour) command into a raster-ordered
// stream of clipped VRAM pixel writes, stallable by the VRAM port's ready signal.
module vram_rect_fill #(
  parameter int H_RES = 160,
  parameter int V_RES = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [7:0]  cmd_x_i,
  input  logic [7:0]  cmd_y_i,
  input  logic [7:0]  cmd_w_i,
  input  logic [7:0]  cmd_h_i,
  input  logic [11:0] cmd_color_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        vram_we_o,
  output logic [15:0] vram_addr_o,
  output logic [11:0] vram_data_o,
  input  logic        vram_ready_i,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a command transfers on an edge with cmd_valid_i && cmd_ready_o;
  // a pixel write retires on an edge with vram_we_o && vram_ready_i.
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_DONE} state_t;

  localparam logic [8:0]  LP_H9  = 9'(H_RES);
  localparam logic [8:0]  LP_V9  = 9'(V_RES);
  localparam logic [15:0] LP_H16 = 16'(H_RES);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_x;
  logic [7:0]  r_y;
  logic [7:0]  r_w;
  logic [7:0]  r_h;
  logic [11:0] r_color;
  logic [8:0]  r_x_end;
  logic [8:0]  r_y_end;
  logic [7:0]  r_col;
  logic [7:0]  r_row;
  logic [15:0] r_row_base;

  logic [8:0]  w_x_sum;
  logic [8:0]  w_y_sum;
  logic [8:0]  w_x_end;
  logic [8:0]  w_y_end;
  logic [15:0] w_y_base;
  logic        w_empty;
  logic        w_retire;
  logic [8:0]  w_col_nxt;
  logic [8:0]  w_row_nxt;
  logic        w_col_wrap;
  logic        w_last;

  // 9-bit sums so x+w and y+h cannot wrap before clipping to the frame.
  assign w_x_sum    = {1'b0, r_x} + {1'b0, r_w};
  assign w_y_sum    = {1'b0, r_y} + {1'b0, r_h};
  assign w_x_end    = (w_x_sum > LP_H9) ? LP_H9 : w_x_sum;
  assign w_y_end    = (w_y_sum > LP_V9) ? LP_V9 : w_y_sum;
  assign w_y_base   = {8'd0, r_y} * LP_H16;
  assign w_empty    = (r_w == 8'd0) || (r_h == 8'd0) ||
                      ({1'b0, r_x} >= LP_H9) || ({1'b0, r_y} >= LP_V9);
  assign w_retire   = (r_state == S_FILL) && vram_ready_i;
  assign w_col_nxt  = {1'b0, r_col} + 9'd1;
  assign w_row_nxt  = {1'b0, r_row} + 9'd1;
  assign w_col_wrap = (w_col_nxt >= r_x_end);
  assign w_last     = w_col_wrap && (w_row_nxt >= r_y_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid_i) w_next = S_SETUP;
      S_SETUP: w_next = w_empty ? S_DONE : S_FILL;
      S_FILL:  if (w_retire && w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort_i && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_color    <= '0;
      r_x_end    <= '0;
      r_y_end    <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
    end else begin
      if ((r_state == S_IDLE) && cmd_valid_i) begin
        r_x     <= cmd_x_i;
        r_y     <= cmd_y_i;
        r_w     <= cmd_w_i;
        r_h     <= cmd_h_i;
        r_color <= cmd_color_i;
      end
      if (r_state == S_SETUP) begin
        r_x_end    <= w_x_end;
        r_y_end    <= w_y_end;
        r_col      <= r_x;
        r_row      <= r_y;
        r_row_base <= w_y_base;
      end
      // A retiring write advances the cursor even on an abort edge.
      if (w_retire) begin
        if (!w_col_wrap) begin
          r_col <= r_col + 8'd1;
        end else begin
          r_col      <= r_x;
          r_row      <= r_row + 8'd1;
          r_row_base <= r_row_base + LP_H16;
        end
      end
    end
  end

  // Address/data are forced to zero outside FILL so the cursor's post-fill
  // position never shows up on the port.
  assign vram_we_o   = (r_state == S_FILL);
  assign vram_addr_o = vram_we_o ? (r_row_base + {8'd0, r_col}) : 16'd0;
  assign vram_data_o = vram_we_o ? r_color : 12'd0;
  assign cmd_ready_o = (r_state == S_IDLE);
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = (r_state == S_DONE);
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_vram_rect_fill.sv
`timescale 1ns/1ps
// Directed bench for vram_rect_fill: negedge monitor feeds an observed-write queue
// that is compared against hand-computed expected pixels.
module tb_vram_rect_fill;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        rst_n = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [7:0]  cmd_x_i = '0;
  logic [7:0]  cmd_y_i = '0;
  logic [7:0]  cmd_w_i = '0;
  logic [7:0]  cmd_h_i = '0;
  logic [11:0] cmd_color_i = '0;
  logic        abort_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        vram_we_o;
  logic [15:0] vram_addr_o;
  logic [11:0] vram_data_o;
  logic        vram_ready_i = 1'b1;
  logic [1:0]  dbg_state_o;

  vram_rect_fill #(.H_RES(160), .V_RES(120)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_x_i      (cmd_x_i),
    .cmd_y_i      (cmd_y_i),
    .cmd_w_i      (cmd_w_i),
    .cmd_h_i      (cmd_h_i),
    .cmd_color_i  (cmd_color_i),
    .abort_i      (abort_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .vram_we_o    (vram_we_o),
    .vram_addr_o  (vram_addr_o),
    .vram_data_o  (vram_data_o),
    .vram_ready_i (vram_ready_i),
    .dbg_state_o  (dbg_state_o)
  );

  // Clock / cycle counter; clk_en lets the clock be frozen low.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard and monitor: entries are {addr[15:0], data[11:0]}.
  logic [27:0] exp_q[$];
  logic [27:0] obs_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_done, n_we, n_acc, acc_edge, done_cyc;

  always @(negedge clk) begin
    if (vram_we_o) begin
      n_we++;
      if (vram_ready_i) obs_q.push_back({vram_addr_o, vram_data_o});
    end
    if (done_o) begin
      n_done++;
      done_cyc = cyc;
    end
    if (cmd_valid_i && cmd_ready_o) begin
      n_acc++;
      acc_edge = cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    obs_q.delete();
    exp_q.delete();
    n_done = 0;
    n_we = 0;
    n_acc = 0;
    acc_edge = -100;
    done_cyc = -1;
  endtask

  task automatic expect_px(input logic [15:0] addr, input logic [11:0] data);
    exp_q.push_back({addr, data});
  endtask

  task automatic check_writes(input string tag);
    logic [27:0] e;
    logic [27:0] o;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_px"}, {4'd0, o}, {4'd0, e});
    end
  endtask

  // Driver: present a command for one edge.
  task automatic send_cmd(input logic [7:0] x, input logic [7:0] y, input logic [7:0] w,
                          input logic [7:0] h, input logic [11:0] c);
    @(posedge clk);
    #1;
    cmd_x_i = x; cmd_y_i = y; cmd_w_i = w; cmd_h_i = h; cmd_color_i = c;
    cmd_valid_i = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, cmd_ready_o, 1);
  endtask

  task automatic run_empty(input string tag, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] w, input logic [7:0] h);
    clear_mon();
    send_cmd(x, y, w, h, 12'hFFF);
    wait_idle(tag);
    check({tag, "_we"}, n_we, 0);
    check({tag, "_done_n"}, n_done, 1);
    // done_o sits in the cycle after edge N+1
    check({tag, "_done_lat"}, done_cyc - acc_edge, 1);
  endtask

  initial begin
    int n;
    clear_mon();
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", cmd_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_we", vram_we_o, 0);
    check("rst_addr", vram_addr_o, 0);
    check("rst_data", vram_data_o, 0);
    check("rst_state", dbg_state_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic fill: rows 5 and 6, columns 10..13
    clear_mon();
    expect_px(16'd810, 12'hF00); expect_px(16'd811, 12'hF00);
    expect_px(16'd812, 12'hF00); expect_px(16'd813, 12'hF00);
    expect_px(16'd970, 12'hF00); expect_px(16'd971, 12'hF00);
    expect_px(16'd972, 12'hF00); expect_px(16'd973, 12'hF00);
    send_cmd(8'd10, 8'd5, 8'd4, 8'd2, 12'hF00);
    wait_idle("basic");
    check_writes("basic");
    check("basic_done_n", n_done, 1);
    check("basic_done_lat", done_cyc - acc_edge, 9);

    // Clipping at the bottom-right corner
    clear_mon();
    expect_px(16'd19198, 12'h0A5); expect_px(16'd19199, 12'h0A5);
    send_cmd(8'd158, 8'd119, 8'd5, 8'd3, 12'h0A5);
    wait_idle("clip");
    check_writes("clip");
    check("clip_done_n", n_done, 1);
    check("clip_done_lat", done_cyc - acc_edge, 3);

    // Empty rectangles
    run_empty("empty_w0", 8'd3, 8'd3, 8'd0, 8'd4);
    run_empty("empty_h0", 8'd3, 8'd3, 8'd4, 8'd0);
    run_empty("empty_x200", 8'd200, 8'd3, 8'd4, 8'd4);

    // Stall: ready low for the first three cycles the first write is presented
    clear_mon();
    expect_px(16'd0, 12'h123); expect_px(16'd1, 12'h123); expect_px(16'd2, 12'h123);
    vram_ready_i = 1'b0;
    send_cmd(8'd0, 8'd0, 8'd3, 8'd1, 12'h123);
    n = 0;
    @(negedge clk);
    while (!vram_we_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_we", vram_we_o, 1);
      check("stall_addr", vram_addr_o, 0);
      check("stall_data", vram_data_o, 12'h123);
    end
    @(posedge clk);
    #1;
    vram_ready_i = 1'b1;
    wait_idle("stall");
    check_writes("stall");
    check("stall_done_n", n_done, 1);
    check("stall_done_lat", done_cyc - acc_edge, 7);

    // Command while busy is ignored
    clear_mon();
    expect_px(16'd1, 12'h0F0); expect_px(16'd2, 12'h0F0);
    send_cmd(8'd1, 8'd0, 8'd2, 8'd1, 12'h0F0);
    @(posedge clk);
    #1;
    cmd_x_i = 8'd50; cmd_y_i = 8'd50; cmd_w_i = 8'd3; cmd_h_i = 8'd3; cmd_color_i = 12'h555;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("busy_ready_low", cmd_ready_o, 0);
    end
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    wait_idle("busy");
    repeat (4) @(negedge clk);
    check_writes("busy");
    check("busy_acc_n", n_acc, 1);
    check("busy_done_n", n_done, 1);

    // Abort after three of eight writes
    clear_mon();
    expect_px(16'd160, 12'hABC); expect_px(16'd161, 12'hABC); expect_px(16'd162, 12'hABC);
    send_cmd(8'd0, 8'd1, 8'd4, 8'd2, 12'hABC);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (obs_q.size() < 3 && n < 50);
    check("abort_reach3", obs_q.size(), 3);
    @(posedge clk);
    #1;
    abort_i = 1'b1;
    vram_ready_i = 1'b0;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    vram_ready_i = 1'b1;
    @(negedge clk);
    check("abort_state", dbg_state_o, 0);
    check("abort_ready", cmd_ready_o, 1);
    check("abort_we", vram_we_o, 0);
    repeat (12) @(negedge clk);
    check("abort_no_done", n_done, 0);
    check_writes("abort");

    // Asynchronous reset mid-fill with the clock frozen low
    clear_mon();
    send_cmd(8'd0, 8'd0, 8'd8, 8'd1, 12'h777);
    n = 0;
    @(negedge clk);
    while (!vram_we_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_started", vram_we_o, 1);
    clk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_we", vram_we_o, 0);
    check("rstmid_busy", busy_o, 0);
    check("rstmid_ready", cmd_ready_o, 1);
    check("rstmid_addr", vram_addr_o, 0);
    #3;
    rst_n = 1'b1;
    clk_en = 1'b1;
    repeat (4) @(negedge clk);
    check("rstmid_no_done", n_done, 0);
    check("rstmid_idle", dbg_state_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
